seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
- Time-multiplexes one shared 4-bit-to-7-segment decoder (segment_7_binary) across NUM_DIGITS common-anode digits.
- Sequences the digit index and drives the decoder's data_in nibble and the active-low anode lines.
- Inserts a blanking interval at the start of each digit slot to prevent ghosting.
- Double-buffers the displayed value so a new value only takes effect on a frame boundary, which prevents tearing.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (index width IDX_W = clog2(NUM_DIGITS), min 1)
DIGIT_CYCLES, 100000, clk cycles per digit slot, blanking included; must be >= 2
BLANK_CYCLES, 1000, clk cycles at the start of each slot with all anodes off; 1 <= BLANK_CYCLES < DIGIT_CYCLES
CNT_W, 17, slot counter width; must hold DIGIT_CYCLES-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
value_in  in  4*NUM_DIGITS  nibble k (bits 4k+3:4k) is shown on digit k; digit 0 is rightmost
load  in  1  single-cycle strobe; captures value_in into the shadow register
digit_mask  in  NUM_DIGITS  1 = digit k enabled; sampled live every cycle
dec_data  out  4  nibble for the current digit; connects to decoder data_in
an  out  NUM_DIGITS  anode enables, active-low, one-cold while driving
cur_digit  out  IDX_W  current digit index
load_pending  out  1  shadow holds a value not yet displayed
frame_tick  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (async assert; deassert is synchronous to clk):
  - shadow, display = 0; load_pending = 0; slot counter = 0; cur_digit = 0; state = BLANK.
  - an = all 1s; dec_data = 0; frame_tick = 0.
  - Asserting rst mid-slot forces an to all 1s immediately, without waiting for clk.
- Slot counter:
  - Increments every clk from 0 to DIGIT_CYCLES-1.
  - At DIGIT_CYCLES-1 it returns to 0 and cur_digit increments modulo NUM_DIGITS.
  - The slot where cur_digit wraps from NUM_DIGITS-1 to 0 is the frame wrap.
- State machine (2 states, registered):
  - BLANK: counter < BLANK_CYCLES. an = all 1s.
  - DRIVE: BLANK_CYCLES <= counter <= DIGIT_CYCLES-1. an[cur_digit] = 0 if digit_mask[cur_digit] = 1, else all 1s; all other bits = 1.
  - BLANK -> DRIVE when the counter reaches BLANK_CYCLES.
  - DRIVE -> BLANK on counter wrap.
- Outputs are registered; an, dec_data, cur_digit and frame_tick change only on clk edges.
- dec_data:
  - Equals display[4*cur_digit+3 : 4*cur_digit].
  - Updates in the first cycle of a slot (during BLANK), so it is stable before the anode turns on.
- Load:
  - On load = 1: shadow <= value_in; load_pending <= 1.
  - Back-to-back loads: the last one before the frame wrap wins.
- Frame wrap, when load = 0: if load_pending, display <= shadow and load_pending <= 0.
- Frame wrap, when load = 1 in the same cycle: display <= value_in directly; load_pending stays or becomes 0. No frame lag.
- Digits later in the current frame keep the old display value; there is no mid-frame update.
- frame_tick:
  - High exactly one cycle: the first cycle of the digit-0 slot following a frame wrap.
  - Not asserted for the first frame after reset.
  - Period = NUM_DIGITS*DIGIT_CYCLES.
- Masked digit: the slot is still consumed (same timing) and an stays all 1s. The mask never alters frame length.
- NUM_DIGITS = 1: cur_digit is constant 0 and every slot is a frame wrap.

Test Plan:
(All scenarios use NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, CNT_W=3; frame length 32 cycles.)
1. Reset:
   - Hold rst 5 cycles -> an=4'b1111, dec_data=0, cur_digit=0, load_pending=0, frame_tick=0.
   - Assert rst asynchronously while an=4'b1011 -> an=4'b1111 before the next clk edge.
2. Basic scan:
   - Pulse load with value_in=16'h1234, digit_mask=4'b1111 before the first wrap (cycle 32).
   - load_pending=1 until cycle 32, then 0.
   - Frame from cycle 32: digit0 dec_data=4 with an=1111 for 2 cycles then 1110 for 6; digit1 dec_data=3, an=1101; digit2 dec_data=2, an=1011; digit3 dec_data=1, an=0111.
3. Anti-tearing:
   - With 16'h1234 displayed, pulse load with 16'hABCD during the digit-2 slot.
   - Digits 2 and 3 still show 2 and 1; load_pending=1.
   - Next frame shows D, C, B, A; load_pending=0.
4. Coincident load and wrap:
   - Pulse load (16'h00F0) in the cycle where counter=7 and cur_digit=3.
   - Next slot shows dec_data=0 for digit0, then F for digit1; load_pending never goes to 1.
   - Double load within one frame (16'h1111 then 16'h2222) -> only 2222 is displayed.
5. Mask:
   - digit_mask=4'b0101 -> an bits 1 and 3 never go low; digit-1 and digit-3 slots show an=1111 for all 8 cycles; frame length stays 32 cycles.
   - Toggle the mask mid-DRIVE -> an follows on the next clk.
6. frame_tick: count pulses over 10 frames -> exactly 10, spaced exactly 32 cycles, each coincident with cur_digit=0 and counter=0.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a shared 7-segment decoder driving common-anode digits.
// Each digit slot opens with a short blanking gap, and the shown value only changes on a frame boundary.
//   state | meaning
//   BLANK | first BLANK_CYCLES of a slot, all anodes off, dec_data settling
//   DRIVE | rest of the slot, current digit's anode on when its mask bit is set
module seg7_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    output logic [3:0]              dec_data,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        cur_digit,
    output logic                    load_pending,
    output logic                    frame_tick
);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [IDX_W-1:0]        digit_nxt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] display_nxt;
    logic                    slot_end;
    logic                    frame_wrap;
    logic                    pending_nxt;
    logic                    drive_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [3:0]              nib_nxt;

    assign slot_end   = (cnt == CNT_W'(DIGIT_CYCLES - 1));
    assign frame_wrap = slot_end && (cur_digit == IDX_W'(NUM_DIGITS - 1));
    assign cnt_nxt    = slot_end ? '0 : cnt + CNT_W'(1);

    always_comb begin
        digit_nxt = cur_digit;
        if (slot_end)
            digit_nxt = frame_wrap ? '0 : cur_digit + IDX_W'(1);
    end

    // A load coinciding with the frame wrap goes straight to display, skipping the shadow.
    always_comb begin
        display_nxt = display;
        pending_nxt = load_pending;
        if (frame_wrap) begin
            pending_nxt = 1'b0;
            if (load)
                display_nxt = value_in;
            else if (load_pending)
                display_nxt = shadow;
        end else if (load) begin
            pending_nxt = 1'b1;
        end
    end

    always_comb begin
        drive_nxt = 1'b0;
        case (state)
            BLANK:   drive_nxt = (cnt_nxt == CNT_W'(BLANK_CYCLES));
            DRIVE:   drive_nxt = !slot_end;
            default: drive_nxt = 1'b0;
        endcase
    end

    always_comb begin
        an_nxt  = '1;
        nib_nxt = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_nxt == IDX_W'(k)) begin
                an_nxt[k] = !(drive_nxt && digit_mask[k]);
                nib_nxt   = display_nxt[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BLANK;
            cnt          <= '0;
            cur_digit    <= '0;
            shadow       <= '0;
            display      <= '0;
            load_pending <= 1'b0;
            an           <= '1;
            dec_data     <= '0;
            frame_tick   <= 1'b0;
        end else begin
            state        <= drive_nxt ? DRIVE : BLANK;
            cnt          <= cnt_nxt;
            cur_digit    <= digit_nxt;
            display      <= display_nxt;
            load_pending <= pending_nxt;
            if (load)
                shadow <= value_in;
            an         <= an_nxt;
            frame_tick <= frame_wrap;
            // New nibble is latched at slot start, while the anodes are still blanked.
            if (slot_end)
                dec_data <= nib_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: per-cycle expectations from a slot/frame arithmetic model.
module tb_seg7_scan_controller;

    localparam int ND = 4;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FL = ND * DC;
    localparam int N  = 40 * FL + 2 * DC + 4;  // ends at digit 2, count 4

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value_in;
    logic          load;
    logic [3:0]    digit_mask;
    logic [3:0]    dec_data;
    logic [3:0]    an;
    logic [1:0]    cur_digit;
    logic          load_pending;
    logic          frame_tick;

    seg7_scan_controller #(
        .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load),
        .digit_mask(digit_mask), .dec_data(dec_data), .an(an),
        .cur_digit(cur_digit), .load_pending(load_pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] dec;
        logic [1:0] cur;
        logic       pend;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   tick_seen = 0;
    int   last_tick = -1;

    task automatic chk(input string name, input int cyc, input int act, input int req);
        tot_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // Monitor: pops one expectation per cycle the DUT presents, sampled between edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("an", e.cyc, an, e.an);
                chk("dec_data", e.cyc, dec_data, e.dec);
                chk("cur_digit", e.cyc, cur_digit, e.cur);
                chk("load_pending", e.cyc, load_pending, e.pend);
                chk("frame_tick", e.cyc, frame_tick, e.tick);
                if (frame_tick) begin
                    tick_seen++;
                    if (last_tick >= 0) chk("tick_spacing", e.cyc, e.cyc - last_tick, FL);
                    last_tick = e.cyc;
                end
            end
        end
    end

    // Reference model: display for frame f = last value loaded during any earlier frame.
    logic [15:0] frame_val;
    logic [15:0] last_val;
    logic        loaded_this_frame;
    logic [3:0]  prev_mask;

    initial begin
        exp_t e;
        int   slot, offs, dig;
        rst = 1'b1; load = 1'b0; value_in = '0; digit_mask = 4'hF;
        frame_val = '0; last_val = '0; loaded_this_frame = 1'b0; prev_mask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_an", -1, an, 4'hF);
            chk("rst_dec", -1, dec_data, 0);
            chk("rst_cur", -1, cur_digit, 0);
            chk("rst_pend", -1, load_pending, 0);
            chk("rst_tick", -1, frame_tick, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            slot = k / DC;
            offs = k % DC;
            dig  = slot % ND;
            if (k > 0 && k % FL == 0) begin
                if (loaded_this_frame) frame_val = last_val;
                loaded_this_frame = 1'b0;
            end
            e.cyc  = k;
            e.cur  = 2'(dig);
            e.dec  = frame_val[4*dig +: 4];
            e.pend = loaded_this_frame;
            e.tick = (k > 0) && (k % FL == 0);
            e.an   = 4'hF;
            if (offs >= BC && prev_mask[dig]) e.an[dig] = 1'b0;
            exp_q.push_back(e);

            load = 1'b0;
            value_in = 16'($urandom);
            if (k < 64) begin
                digit_mask = 4'hF;
                if (k == 5) begin load = 1'b1; value_in = 16'h1234; end
            end else if (k < 160) begin
                digit_mask = 4'hF;
                if (k == 83)  begin load = 1'b1; value_in = 16'hABCD; end
                if (k == 127) begin load = 1'b1; value_in = 16'h00F0; end
                if (k == 130) begin load = 1'b1; value_in = 16'h1111; end
                if (k == 140) begin load = 1'b1; value_in = 16'h2222; end
            end else if (k < 224) begin
                digit_mask = 4'b0101;
            end else if (k < 256) begin
                digit_mask = 4'($urandom);
            end else if (k < 40 * FL) begin
                if ($urandom_range(0, 9) == 0) load = 1'b1;
                if ($urandom_range(0, 7) == 0) digit_mask = 4'($urandom);
            end else begin
                digit_mask = 4'hF;
            end
            if (load) begin
                last_val = value_in;
                loaded_this_frame = 1'b1;
            end
            prev_mask = digit_mask;
            @(negedge clk);
        end
        load = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", N, exp_q.size(), 0);
        chk("tick_count", N, tick_seen, (N - 1) / FL);

        #2;
        chk("pre_async_an", N, an, 4'b1011);
        rst = 1'b1;
        #1;
        chk("async_rst_an", N, an, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst2_an", -2, an, 4'hF);
            chk("rst2_dec", -2, dec_data, 0);
            chk("rst2_cur", -2, cur_digit, 0);
            chk("rst2_pend", -2, load_pending, 0);
            chk("rst2_tick", -2, frame_tick, 0);
        end
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", pass_cnt, tot_cnt);
        $fatal(1, "timeout");
    end

endmodule
